// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared constants for the GPIO interrupt controller: bus offsets, default sizing
// and the byte-lane mask helper used by every register write.
package gpio_irq_ctrl_pkg;

    localparam int MEM_W    = 32;
    localparam int NSRC_DEF = 16;
    localparam int ID_W_DEF = 5;

    localparam logic [7:0] OFF_IPD = 8'h00;
    localparam logic [7:0] OFF_IEN = 8'h04;
    localparam logic [7:0] OFF_CLM = 8'h08;
    localparam logic [7:0] OFF_OVF = 8'h0C;
    localparam logic [7:0] OFF_ISW = 8'h10;

    function automatic logic [MEM_W-1:0] byte_mask(input logic [3:0] sel);
        logic [MEM_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_irq_prio.sv
// Combinational lowest-index-wins priority encoder: NSRC requests -> {valid, id}.
module gpio_irq_prio
    import gpio_irq_ctrl_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [NSRC-1:0] req_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    // Scan downward so the last hit, i.e. the lowest index, is the one that sticks.
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Sticky-pending, maskable interrupt controller with read-to-claim priority.
// Optional overflow flags are built only when GPIO_IRQ_OVF_EN is defined.
module gpio_irq_ctrl
    import gpio_irq_ctrl_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       waddr_i,
    input  logic [MEM_W-1:0] data_i,
    input  logic [3:0]       sel_i,
    input  logic             we_i,
    input  logic [7:0]       raddr_i,
    input  logic             rd_i,
    output logic [MEM_W-1:0] data_o,
    input  logic [NSRC-1:0]  irq_i,
    output logic             irq_o
);

    logic [NSRC-1:0]  pend_q, pend_d;
    logic [NSRC-1:0]  ien_q, ien_d;
    logic [MEM_W-1:0] data_q, data_d;
    logic             irq_q, irq_d;

    logic [NSRC-1:0]  wmask, wbits, clr_all, set_all, claim_clr;
    logic             claim, claim_valid;
    logic [ID_W-1:0]  claim_id;
    logic             unused_hi;

    assign wmask     = NSRC'(byte_mask(sel_i));
    assign wbits     = NSRC'(data_i) & wmask;
    assign unused_hi = ^(data_i >> NSRC);

    gpio_irq_prio #(.NSRC(NSRC), .ID_W(ID_W)) u_prio (
        .req_i   (pend_q & ien_q),
        .valid_o (claim_valid),
        .id_o    (claim_id)
    );

    assign claim     = rd_i && (raddr_i == OFF_CLM);
    assign claim_clr = (claim && claim_valid) ? (NSRC'(1) << claim_id) : '0;
    assign clr_all   = ((we_i && waddr_i == OFF_IPD) ? wbits : '0) | claim_clr;
    assign set_all   = irq_i | ((we_i && waddr_i == OFF_ISW) ? wbits : '0);

    // Set has priority over clear so a pulse coinciding with W1C/claim is never lost.
    assign pend_d = (pend_q & ~clr_all) | set_all;
    assign ien_d  = (we_i && waddr_i == OFF_IEN) ? ((ien_q & ~wmask) | wbits) : ien_q;
    assign irq_d  = |(pend_q & ien_q);

`ifdef GPIO_IRQ_OVF_EN
    logic [NSRC-1:0] ovf_q, ovf_d;
    assign ovf_d = (ovf_q & ~((we_i && waddr_i == OFF_OVF) ? wbits : '0))
                 | (irq_i & pend_q & ~clr_all);
`endif

    always_comb begin
        data_d = data_q;
        if (rd_i) begin
            case (raddr_i)
                OFF_IPD: data_d = MEM_W'(pend_q);
                OFF_IEN: data_d = MEM_W'(ien_q);
                OFF_CLM: data_d = claim_valid ? (32'h8000_0000 | MEM_W'(claim_id)) : '0;
`ifdef GPIO_IRQ_OVF_EN
                OFF_OVF: data_d = MEM_W'(ovf_q);
`endif
                default: data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ien_q  <= '0;
            data_q <= '0;
            irq_q  <= 1'b0;
`ifdef GPIO_IRQ_OVF_EN
            ovf_q  <= '0;
`endif
        end else begin
            pend_q <= pend_d;
            ien_q  <= ien_d;
            data_q <= data_d;
            irq_q  <= irq_d;
`ifdef GPIO_IRQ_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl against a per-bit behavioural model.
module tb_gpio_irq_ctrl;

    localparam int NSRC = 16;

    logic        clk, rst_n;
    logic [7:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we, rd;
    logic [15:0] irq;
    logic [31:0] data_o;
    logic        irq_o;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_pend, m_ien, m_ovf, m_data;
    logic        m_irq;
`ifdef GPIO_IRQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    gpio_irq_ctrl #(.NSRC(16), .ID_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waddr_i (waddr),
        .data_i  (wdata),
        .sel_i   (sel),
        .we_i    (we),
        .raddr_i (raddr),
        .rd_i    (rd),
        .data_o  (data_o),
        .irq_i   (irq),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_ien = '0; m_ovf = '0; m_data = '0; m_irq = 1'b0;
    endtask

    // Applies the register-map rules to the inputs present at this clock edge.
    task automatic model_edge();
        logic [31:0] p, e, o;
        int claim_k;
        bit wb, clr, st;
        p = m_pend; e = m_ien; o = m_ovf;
        claim_k = -1;
        m_irq = ((p & e) != 0);
        if (rd) begin
            case (raddr)
                8'h00: m_data = p;
                8'h04: m_data = e;
                8'h08: begin
                    m_data = 0;
                    for (int k = 0; k < NSRC; k++) begin
                        if (claim_k < 0 && p[k] && e[k]) claim_k = k;
                    end
                    if (claim_k >= 0) m_data = 32'h8000_0000 + claim_k;
                end
                8'h0C: m_data = OVF_EN ? o : 32'h0;
                default: m_data = 0;
            endcase
        end
        for (int k = 0; k < NSRC; k++) begin
            wb  = we && sel[k/8] && wdata[k];
            clr = (wb && waddr == 8'h00) || (claim_k == k);
            st  = irq[k] || (wb && waddr == 8'h10);
            if (OVF_EN)
                m_ovf[k] = (o[k] && !(wb && waddr == 8'h0C)) || (irq[k] && p[k] && !clr);
            m_pend[k] = (p[k] && !clr) || st;
            if (we && waddr == 8'h04 && sel[k/8]) m_ien[k] = wdata[k];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        we = 0; rd = 0; irq = '0; sel = 4'hF; wdata = '0; waddr = '0; raddr = '0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        we = 1; waddr = a; wdata = d; sel = 4'hF;
        cycle();
    endtask

    task automatic do_read(input logic [7:0] a);
        rd = 1; raddr = a;
        cycle();
    endtask

    task automatic clear_all();
        do_write(8'h04, 32'h0);
        do_write(8'h00, 32'hFFFF_FFFF);
        do_write(8'h0C, 32'hFFFF_FFFF);
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 0; we = 0; rd = 0; irq = '0; sel = 4'hF; wdata = '0; waddr = '0; raddr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        vectors++;
        if (data_o !== 32'h0 || irq_o !== 1'b0) begin
            errors++; $display("FAIL reset_out: data_o=%h irq_o=%b required 0/0", data_o, irq_o);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(8'(i * 4));
            vectors++;
            if (data_o !== 32'h0) begin
                errors++; $display("FAIL reset_reg%0d: got %h required 0", i, data_o);
            end
        end
    endtask

    task automatic test_pend_irq();
        do_write(8'h04, 32'h1);
        irq[0] = 1;
        cycle();                         // edge N: pending latches
        vectors++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL pend_irq_early: irq_o=%b required 0", irq_o);
        end
        do_read(8'h00);                  // edge N+1
        vectors++;
        if (data_o !== 32'h1 || data_o !== m_data || irq_o !== 1'b1) begin
            errors++; $display("FAIL pend_irq: IPD=%h irq_o=%b required 00000001/1", data_o, irq_o);
        end
        clear_all();
    endtask

    task automatic test_claim();
        do_write(8'h10, 32'h14);
        do_write(8'h04, 32'hFFFF);
        do_read(8'h08);
        vectors++;
        if (data_o !== 32'h8000_0002 || data_o !== m_data) begin
            errors++; $display("FAIL claim1: got %h required 80000002", data_o);
        end
        do_read(8'h08);
        vectors++;
        if (data_o !== 32'h8000_0004 || irq_o !== 1'b1) begin
            errors++; $display("FAIL claim2: got %h irq_o=%b required 80000004/1", data_o, irq_o);
        end
        do_read(8'h08);
        vectors++;
        if (data_o !== 32'h0 || irq_o !== 1'b0 || irq_o !== m_irq) begin
            errors++; $display("FAIL claim3: got %h irq_o=%b required 0/0", data_o, irq_o);
        end
        clear_all();
    endtask

    task automatic test_masked();
        irq[5] = 1;
        cycle();
        cycle();
        do_read(8'h00);
        vectors++;
        if (data_o !== 32'h20 || irq_o !== 1'b0) begin
            errors++; $display("FAIL masked: IPD=%h irq_o=%b required 00000020/0", data_o, irq_o);
        end
        do_write(8'h04, 32'h20);
        cycle();
        vectors++;
        if (irq_o !== 1'b1 || irq_o !== m_irq) begin
            errors++; $display("FAIL unmask: irq_o=%b required 1", irq_o);
        end
        clear_all();
    endtask

    task automatic test_set_wins();
        irq[3] = 1;
        cycle();
        we = 1; waddr = 8'h00; wdata = 32'h8; sel = 4'hF; irq[3] = 1;
        cycle();
        do_read(8'h00);
        vectors++;
        if (data_o !== 32'h8 || data_o !== m_data) begin
            errors++; $display("FAIL set_wins: IPD=%h required 00000008", data_o);
        end
        clear_all();
    endtask

    task automatic test_ovf();
        irq[7] = 1; cycle();
        cycle();
        irq[7] = 1; cycle();
        do_read(8'h0C);
        vectors++;
        if (data_o !== (OVF_EN ? 32'h80 : 32'h0)) begin
            errors++; $display("FAIL ovf_set: OVF=%h required %h", data_o, OVF_EN ? 32'h80 : 32'h0);
        end
        do_write(8'h0C, 32'h80);
        do_read(8'h0C);
        vectors++;
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL ovf_clr: OVF=%h required 0", data_o);
        end
        clear_all();
    endtask

    task automatic test_random();
        logic [7:0] offs [6];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        for (int i = 0; i < 400; i++) begin
            we    = ($urandom_range(0, 3) == 0);
            waddr = offs[$urandom_range(0, 5)];
            wdata = $urandom;
            sel   = 4'($urandom_range(0, 15));
            rd    = ($urandom_range(0, 1) == 0);
            raddr = offs[$urandom_range(0, 5)];
            irq   = 16'($urandom & $urandom & $urandom);
            cycle();
            vectors++;
            if (data_o !== m_data || irq_o !== m_irq) begin
                errors++;
                $display("FAIL random[%0d]: data_o=%h irq_o=%b required %h/%b", i, data_o, irq_o, m_data, m_irq);
            end
        end
        clear_all();
    endtask

    task automatic test_async_reset();
        do_write(8'h10, 32'h8000);
        do_write(8'h04, 32'h8000);
        cycle();
        do_read(8'h00);
        vectors++;
        if (irq_o !== 1'b1 || data_o !== 32'h8000) begin
            errors++; $display("FAIL isw_irq: irq_o=%b IPD=%h required 1/00008000", irq_o, data_o);
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        vectors++;
        if (irq_o !== 1'b0 || data_o !== 32'h0) begin
            errors++; $display("FAIL async_reset: irq_o=%b data_o=%h required 0/0", irq_o, data_o);
        end
        @(negedge clk) rst_n = 1;
        do_read(8'h00);
        do_read(8'h04);
        vectors++;
        if (data_o !== 32'h0 || irq_o !== 1'b0) begin
            errors++; $display("FAIL post_reset: IEN=%h irq_o=%b required 0/0", data_o, irq_o);
        end
    endtask

    initial begin
        test_reset();
        test_pend_irq();
        test_claim();
        test_masked();
        test_set_wins();
        test_ovf();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
